// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared types and constants for the multicycle control unit
//
// Purpose: state encoding, RV64 opcode constants and the wait counter width
// used by unidade_controle and uc_decodificador.
// Ports: none (package).
// Configuration: UC_TRAP_EN adds the S_TRAP state to the state type.

package uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef UC_TRAP_EN
    , S_TRAP
`endif
  } uc_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int WAIT_W = 4;

  // True for every opcode the datapath knows how to sequence.
  function automatic logic op_is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/uc_decodificador.sv
// rtl/uc_decodificador.sv - opcode classifier for the control unit
//
// Purpose: purely combinational decode of the latched opcode into one-hot
// instruction class flags. Exactly one output is high for any input.
// Ports:
//   op_q        in  7  opcode latched in DECODE
//   is_r        out 1  R-type ALU operation
//   is_i        out 1  I-type ALU operation
//   is_load     out 1  load
//   is_store    out 1  store
//   is_branch   out 1  conditional branch
//   is_illegal  out 1  none of the above

module uc_decodificador
  import uc_pkg::*;
(
  input  logic [6:0] op_q,
  output logic       is_r,
  output logic       is_i,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_illegal
);

  assign is_r       = (op_q == OP_R);
  assign is_i       = (op_q == OP_I);
  assign is_load    = (op_q == OP_LOAD);
  assign is_store   = (op_q == OP_STORE);
  assign is_branch  = (op_q == OP_BRANCH);
  assign is_illegal = !op_is_legal(op_q);

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle control unit for the RV64 datapath
//
// Purpose: sequences PC/IR/register bank/data memory write enables and the
// datapath mux selects, one instruction at a time, from the IR opcode.
// All outputs are Moore outputs decoded from the state and the opcode
// latched in DECODE; the live opcode only steers the DECODE transition.
// Parameters:
//   MEM_WAIT    extra cycles held in MEM for loads/stores (0-15)
// Ports:
//   clock       in  1  rising-edge clock
//   reset       in  1  synchronous, active-high
//   opcode      in  7  IR[6:0]
//   we_pc       out 1  PC write enable (once per instruction, with retired)
//   we_ir       out 1  IR write enable (FETCH)
//   we_reg      out 1  register bank write enable (WB)
//   we_mem      out 1  data memory write enable (last MEM cycle of a store)
//   sinal_mux1  out 1  ULA operand B: 1 = doutB, 0 = imm
//   sinal_mux2  out 1  register write data: 0 = ULA, 1 = memory
//   flag_en     out 1  branch qualify for Mux3
//   retired     out 1  pulse in the final state of each instruction
//   illegal     out 1  high while trapped (only with UC_TRAP_EN)
// Configuration: UC_TRAP_EN enables the TRAP state and the illegal port;
// without it an unknown opcode retires as a NOP.

module unidade_controle
  import uc_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  output logic       we_pc,
  output logic       we_ir,
  output logic       we_reg,
  output logic       we_mem,
  output logic       sinal_mux1,
  output logic       sinal_mux2,
  output logic       flag_en,
  output logic       retired
`ifdef UC_TRAP_EN
  ,
  output logic       illegal
`endif
);

  localparam logic [WAIT_W-1:0] MEM_WAIT_L = WAIT_W'(MEM_WAIT);

  uc_state_e         state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic is_r, is_i, is_load, is_store, is_branch, is_illegal;

  uc_decodificador u_decodificador (
    .op_q       (op_q),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = wait_q;
    we_pc      = 1'b0;
    we_ir      = 1'b0;
    we_reg     = 1'b0;
    we_mem     = 1'b0;
    sinal_mux1 = 1'b0;
    sinal_mux2 = 1'b0;
    flag_en    = 1'b0;
    retired    = 1'b0;
`ifdef UC_TRAP_EN
    illegal    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        we_ir   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        op_d = opcode;
        // op_q is not valid yet, so the trap decision looks at the live opcode.
`ifdef UC_TRAP_EN
        if (!op_is_legal(opcode)) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
`else
        state_d = S_EXEC;
`endif
      end

      S_EXEC: begin
        sinal_mux1 = is_r || is_branch;
        if (is_branch) begin
          flag_en = 1'b1;
          we_pc   = 1'b1;
          retired = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          wait_d  = MEM_WAIT_L;
          state_d = S_MEM;
        end else if (is_r || is_i) begin
          state_d = S_WB;
        end else if (is_illegal) begin
          // Unknown opcode: retire as a NOP (PC+4, no writes).
          we_pc   = 1'b1;
          retired = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        // Only loads and stores reach MEM; the counter was loaded on entry.
        if (wait_q == '0) begin
          if (is_store) begin
            we_mem  = 1'b1;
            we_pc   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_WB: begin
        we_reg     = 1'b1;
        we_pc      = 1'b1;
        retired    = 1'b1;
        sinal_mux2 = is_load;
        // Operand B select held at its EXEC value (0 for loads and I-ALU).
        sinal_mux1 = is_r;
        state_d    = S_FETCH;
      end

`ifdef UC_TRAP_EN
      S_TRAP: begin
        illegal = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - self-checking bench for unidade_controle

module tb_unidade_controle;

  localparam int MW = 2;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  typedef struct packed {
    logic we_pc;
    logic we_ir;
    logic we_reg;
    logic we_mem;
    logic mux1;
    logic mux2;
    logic flag_en;
    logic retired;
    logic illegal;
  } outs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       we_pc, we_ir, we_reg, we_mem, sinal_mux1, sinal_mux2, flag_en, retired;
  logic       illegal_w;

  int n_checks = 0;
  int n_fail   = 0;

  outs_t exp_q[$];

  always #5 clock = ~clock;

  unidade_controle #(.MEM_WAIT(MW)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .we_pc      (we_pc),
    .we_ir      (we_ir),
    .we_reg     (we_reg),
    .we_mem     (we_mem),
    .sinal_mux1 (sinal_mux1),
    .sinal_mux2 (sinal_mux2),
    .flag_en    (flag_en),
    .retired    (retired)
`ifdef UC_TRAP_EN
    ,
    .illegal    (illegal_w)
`endif
  );

`ifndef UC_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  function automatic outs_t sample();
    return {we_pc, we_ir, we_reg, we_mem, sinal_mux1, sinal_mux2, flag_en, retired, illegal_w};
  endfunction

  task automatic check(input string tag, input outs_t e);
    outs_t o;
    o = sample();
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (we_pc,we_ir,we_reg,we_mem,mux1,mux2,flag_en,retired,illegal)",
             tag, o, e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Expected per-cycle outputs from FETCH to the retiring cycle, derived from
  // the instruction class and the MEM wait count.
  task automatic build(input logic [6:0] op);
    outs_t e;
    logic  r, i, ld, st, br, legal;
    r  = (op == T_R);
    i  = (op == T_I);
    ld = (op == T_LOAD);
    st = (op == T_STORE);
    br = (op == T_BRANCH);
    legal = r | i | ld | st | br;
    exp_q.delete();
    e = '0; e.we_ir = 1'b1; exp_q.push_back(e);
    e = '0; exp_q.push_back(e);
`ifdef UC_TRAP_EN
    if (!legal) begin
      e = '0; e.illegal = 1'b1;
      repeat (5) exp_q.push_back(e);
      return;
    end
`endif
    if (br) begin
      e = '0; e.mux1 = 1'b1; e.flag_en = 1'b1; e.we_pc = 1'b1; e.retired = 1'b1;
      exp_q.push_back(e);
    end else if (r || i) begin
      e = '0; e.mux1 = r; exp_q.push_back(e);
      e.we_reg = 1'b1; e.we_pc = 1'b1; e.retired = 1'b1; exp_q.push_back(e);
    end else if (ld || st) begin
      e = '0;
      exp_q.push_back(e);
      repeat (MW) exp_q.push_back(e);
      if (st) begin
        e.we_mem = 1'b1; e.we_pc = 1'b1; e.retired = 1'b1; exp_q.push_back(e);
      end else begin
        exp_q.push_back(e);
        e.we_reg = 1'b1; e.we_pc = 1'b1; e.retired = 1'b1; e.mux2 = 1'b1;
        exp_q.push_back(e);
      end
    end else begin
      e = '0; e.we_pc = 1'b1; e.retired = 1'b1; exp_q.push_back(e);
    end
  endtask

  // Entered at the FETCH negedge; returns at the next FETCH negedge, or, when
  // abort_at >= 0, with reset raised at that cycle.
  task automatic run_instr(input logic [6:0] op, input string tag, input int abort_at = -1);
    build(op);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 1) opcode = op;
      else        opcode = 7'($urandom);
      check($sformatf("%s_c%0d", tag, k), exp_q[k]);
      if (k == abort_at) begin
        reset = 1'b1;
        return;
      end
      next_cycle();
    end
  endtask

  // Reset is already (or now) high; holds it for n edges, releases it in the
  // IDLE cycle and returns at the first FETCH negedge.
  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      next_cycle();
      check($sformatf("%s_rst%0d", tag, k), outs_t'(0));
    end
    reset = 1'b0;
    next_cycle();
  endtask

  initial begin
    logic [6:0] pool [5];
    logic [6:0] op;
    pool[0] = T_R; pool[1] = T_I; pool[2] = T_LOAD; pool[3] = T_STORE; pool[4] = T_BRANCH;

    @(negedge clock);
    do_reset(3, "init");

    run_instr(T_BRANCH, "branch");
    run_instr(T_R, "rtype");
    run_instr(T_I, "itype");
    run_instr(T_LOAD, "load");
    run_instr(T_STORE, "store");

    // Reset lands in the first MEM cycle of a store: the pending write is dropped.
    run_instr(T_STORE, "store_abort", 3);
    do_reset(1, "mid_mem");
    run_instr(T_R, "after_abort");

    for (int n = 0; n < 40; n++) begin
`ifdef UC_TRAP_EN
      op = pool[$urandom_range(0, 4)];
`else
      if ($urandom_range(0, 5) == 5) op = 7'($urandom);
      else                           op = pool[$urandom_range(0, 4)];
`endif
      run_instr(op, $sformatf("rnd%0d_op%b", n, op));
    end

    run_instr(T_BAD, "illegal");
`ifdef UC_TRAP_EN
    do_reset(1, "trap_exit");
`endif
    run_instr(T_BRANCH, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
